factorial_ctrl: RTL and testbench
=================================

# factorial_ctrl

Moore FSM controller that sequences the 8-bit factorial `datapath` (registers `i`, `fi`, output register `fi_out`) to compute X! on request. It accepts a start/operand handshake, latches X, drives the datapath's `ld_i`/`ld_fi`/`ld_o`/`st` strobes from `i_lt_x` feedback, and reports completion with a one-cycle `done` pulse. It sits between the system requester and `datapath`, one controller per datapath instance.

## Interface
- `W`, 8, operand/result width (matches datapath)
- `MAX_N`, 5, largest X whose factorial fits in `W` bits (used only with overflow detection)
- `CLK`  in  1  clock; all state changes on rising edge
- `RST`  in  1  reset, synchronous, active-high
- `start`  in  1  request; accepted only in IDLE
- `abort`  in  1  synchronous cancel; returns to IDLE next edge
- `X_in`  in  W  operand, sampled on start acceptance
- `i_lt_x`  in  1  datapath compare flag (i < X)
- `X`  out  W  latched operand driven to datapath
- `ld_i`, `ld_fi`, `ld_o`  out  1  datapath load strobes
- `st`  out  1  datapath select: 1 = initialise (i←1, fi←1), 0 = update (i←i+1, fi←fi·i)
- `busy`  out  1  high from start acceptance until DONE exits
- `done`  out  1  one-cycle pulse; `fi_out` valid from this cycle
- `iter`  out  W  loop iterations executed for current/last run
- `ovf`  out  1  overflow flag (only with FACT_OVF_DET_EN; else tied 0)

## Operation
- States: IDLE, INIT_I, INIT_FI, CHECK, INC_I, MUL_FI, LOAD_O, DONE.
- IDLE: `st`=1, strobes 0. `start`=1 and `abort`=0 → latch `X_in` into `X`, clear `iter`, go INIT_I.
- INIT_I: `ld_i`=1, `st`=1 → INIT_FI. INIT_FI: `ld_fi`=1, `st`=1 → CHECK.
- CHECK: no strobes, `st`=0; `i_lt_x`=1 → INC_I, else LOAD_O.
- INC_I: `ld_i`=1, `st`=0, `iter`+=1 → MUL_FI. MUL_FI: `ld_fi`=1, `st`=0 → CHECK.
- LOAD_O: `ld_o`=1 → DONE. DONE: `done`=1 → IDLE unconditionally.
- Exactly one strobe asserted per cycle; never two simultaneously.
- `start` outside IDLE (including DONE) ignored; no queueing.
- `abort` in any state → IDLE next edge, no `ld_o`; `fi_out` keeps prior value; `X`, `iter` hold. `abort` with `start` in IDLE: abort wins.
- X = 0 or 1: CHECK sees `i_lt_x`=0 immediately; result 1, `iter`=0.
- `iter` saturates at 2^W−1 (unreachable for W=8 but required).

## Timing
- Reset (RST=1 at edge): state IDLE, `X`=0, `iter`=0, `ld_i`=`ld_fi`=`ld_o`=0, `st`=1, `busy`=0, `done`=0, `ovf`=0. RST overrides `start`/`abort`.
- Outputs decoded from state register only (Moore); no combinational path from inputs to outputs.
- `i_lt_x` sampled only in CHECK, ≥1 cycle after last `ld_i`, so datapath compare is settled.
- Latency, start-accept edge to `done` cycle: 5 cycles for X≤1; 5 + 3·(X−1) for X≥2 (X=3 → 11, X=5 → 17).
- `busy` rises the cycle after acceptance, falls the cycle after `done`. Next `start` accepted one cycle after `done`.

## Configuration
- `FACT_OVF_DET_EN` defined: at acceptance `ovf` ← (X_in > MAX_N); held until next acceptance or reset; computation still runs to completion (truncated result).
- Undefined: no compare logic, `ovf` tied 0.

## Structure
- `factorial_pkg`: state enum (8 states, 3-bit encoding), `W` default, `MAX_N` default, datapath `st` encoding constants (ST_INIT=1, ST_UPD=0).
- Single module; no sub-module — FSM, operand latch and `iter` counter are too small to split.
- Bench instantiates `factorial_ctrl` + `datapath` together.

## Test plan
- RST held 2 cycles, release, no start → all outputs at reset values, state IDLE, `st`=1.
- X_in=3, start 1 cycle → `done` 11 cycles after acceptance, `fi_out`=6, `iter`=2, strobe order ld_i,ld_fi,(ld_i,ld_fi)×2,ld_o.
- X_in=0, then X_in=1 → each `done` after 5 cycles, `fi_out`=1, `iter`=0.
- X_in=5 → `fi_out`=120, latency 17; start pulsed mid-run is ignored, result unchanged.
- X_in=4, `abort` in the 2nd MUL_FI → IDLE next edge, no `ld_o`, `fi_out` keeps previous 120, `busy`=0; new start X=2 → `fi_out`=2.
- With FACT_OVF_DET_EN, X_in=6 → `ovf`=1, `done` after 20 cycles, `fi_out`=720 mod 256=208; next run X=4 clears `ovf`, result 24.

Source files
------------

// File: rtl/factorial_pkg.sv
// factorial_pkg: shared FSM state encoding, width defaults and datapath select codes
package factorial_pkg;
  typedef enum logic [2:0] {IDLE, INIT_I, INIT_FI, CHECK, INC_I, MUL_FI, LOAD_O, DONE} state_t;
  localparam int W_DEF = 8;
  localparam int MAX_N_DEF = 5;
  localparam logic ST_INIT = 1'b1;
  localparam logic ST_UPD = 1'b0;
endpackage

// File: rtl/factorial_ctrl.sv
// factorial_ctrl: Moore FSM sequencing the factorial datapath; defining FACT_OVF_DET_EN adds the operand overflow flag
module factorial_ctrl
  import factorial_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int MAX_N = MAX_N_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] X_in,
  input  logic         i_lt_x,
  output logic [W-1:0] X,
  output logic         ld_i,
  output logic         ld_fi,
  output logic         ld_o,
  output logic         st,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] iter,
  output logic         ovf
);
  state_t state_q, state_d;
  logic [W-1:0] x_q, x_d, iter_q, iter_d;
  logic accept;
  always_comb begin
    accept = state_q == IDLE && start && !abort;
    x_d = accept ? X_in : x_q;
    iter_d = accept ? '0 : (state_q == INC_I && !abort && iter_q != '1) ? iter_q + W'(1) : iter_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? INIT_I : IDLE;
      INIT_I:  state_d = INIT_FI;
      INIT_FI: state_d = CHECK;
      CHECK:   state_d = i_lt_x ? INC_I : LOAD_O;
      INC_I:   state_d = MUL_FI;
      MUL_FI:  state_d = CHECK;
      LOAD_O:  state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      x_q <= '0;
      iter_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      iter_q <= iter_d;
    end
  end
  assign X = x_q;
  assign iter = iter_q;
  assign ld_i = state_q == INIT_I || state_q == INC_I;
  assign ld_fi = state_q == INIT_FI || state_q == MUL_FI;
  assign ld_o = state_q == LOAD_O;
  assign st = (state_q == IDLE || state_q == INIT_I || state_q == INIT_FI) ? ST_INIT : ST_UPD;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
`ifdef FACT_OVF_DET_EN
  logic ovf_q, ovf_d;
  always_comb ovf_d = accept ? (X_in > W'(MAX_N)) : ovf_q;
  always_ff @(posedge CLK) ovf_q <= RST ? 1'b0 : ovf_d;
  assign ovf = ovf_q;
`else
  logic unused_max_n;
  assign unused_max_n = MAX_N > 0;
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_factorial_ctrl.sv
// tb_factorial_ctrl: controller plus behavioural datapath, directed runs checked by a done-driven scoreboard
module tb_factorial_ctrl;
  import factorial_pkg::*;
  logic CLK = 1'b0, RST = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0] X_in = 8'd0;
  logic [7:0] X, iter, i_r, fi_r, fi_out;
  logic i_lt_x, ld_i, ld_fi, ld_o, st, busy, done, ovf;
  int checks = 0, passes = 0, cyc = 0;
  string seq = "";
  typedef struct {
    logic [7:0] fi;
    logic [7:0] it;
    int lat;
    logic ov;
    int acc;
  } exp_t;
  exp_t sbq[$];
`ifdef FACT_OVF_DET_EN
  localparam logic OVF6 = 1'b1;
`else
  localparam logic OVF6 = 1'b0;
`endif

  always #5 CLK = ~CLK;

  factorial_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .X_in(X_in), .i_lt_x(i_lt_x),
    .X(X), .ld_i(ld_i), .ld_fi(ld_fi), .ld_o(ld_o), .st(st), .busy(busy), .done(done),
    .iter(iter), .ovf(ovf)
  );

  assign i_lt_x = i_r < X;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RST) begin
      i_r <= 8'd0;
      fi_r <= 8'd0;
      fi_out <= 8'd0;
    end else begin
      if (ld_i) i_r <= st ? 8'd1 : i_r + 8'd1;
      if (ld_fi) fi_r <= st ? 8'd1 : fi_r * i_r;
      if (ld_o) fi_out <= fi_r;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      chk("one_strobe", 32'($countones({ld_i, ld_fi, ld_o}) <= 1), 1);
      if (!busy) seq = "";
      if (ld_i) seq = {seq, "I"};
      if (ld_fi) seq = {seq, "F"};
      if (ld_o) seq = {seq, "O"};
      if (done) begin
        chk("sb_has_entry", 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("fi_out", fi_out, e.fi);
          chk("iter", iter, e.it);
          chk("latency", cyc - e.acc + 1, e.lat);
          chk("ovf", ovf, e.ov);
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 50) begin
      @(negedge CLK);
      k++;
    end
    chk("idle_before_start", busy, 0);
  endtask

  task automatic run(input logic [7:0] x, input logic [7:0] efi, input logic [7:0] eit,
                     input int elat, input logic eov, input bit mid);
    int k = 0;
    exp_t e;
    wait_idle();
    start = 1'b1;
    X_in = x;
    @(posedge CLK);
    #1 start = 1'b0;
    e = '{efi, eit, elat, eov, cyc};
    sbq.push_back(e);
    while (!done && k < 40) begin
      @(negedge CLK);
      k++;
      if (mid && k == 6) begin
        start = 1'b1;
        X_in = 8'd2;
      end else start = 1'b0;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    int k, m;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_X", X, 0);
    chk("rst_iter", iter, 0);
    chk("rst_ld_i", ld_i, 0);
    chk("rst_ld_fi", ld_fi, 0);
    chk("rst_ld_o", ld_o, 0);
    chk("rst_st", st, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    run(8'd3, 8'd6, 8'd2, 11, 1'b0, 1'b0);
    chk("strobe_order", 32'(seq == "IFIFIFO"), 1);
    run(8'd0, 8'd1, 8'd0, 5, 1'b0, 1'b0);
    run(8'd1, 8'd1, 8'd0, 5, 1'b0, 1'b0);
    run(8'd5, 8'd120, 8'd4, 17, 1'b0, 1'b1);
    wait_idle();
    start = 1'b1;
    X_in = 8'd4;
    @(posedge CLK);
    #1 start = 1'b0;
    k = 0;
    m = 0;
    while (m < 2 && k < 40) begin
      @(negedge CLK);
      k++;
      if (ld_fi && st == ST_UPD) m++;
    end
    chk("second_mul_reached", m, 2);
    abort = 1'b1;
    @(posedge CLK);
    #1 abort = 1'b0;
    @(negedge CLK);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_iter_hold", iter, 2);
    chk("abort_X_hold", X, 4);
    repeat (4) begin
      @(negedge CLK);
      chk("abort_no_ld_o", ld_o, 0);
    end
    chk("abort_fi_out_kept", fi_out, 120);
    run(8'd2, 8'd2, 8'd1, 8, 1'b0, 1'b0);
    run(8'd6, 8'd208, 8'd5, 20, OVF6, 1'b0);
    run(8'd4, 8'd24, 8'd3, 14, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
